pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning address width; legal values are 8 to 64.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, meaning the return-address-stack entry count; it is a power of 2 and at least 2.
REQ-003 The block SHALL have parameter NUM_IRQ, default 4, meaning the interrupt line count; legal values are 1 to 16.
REQ-004 The block SHALL use reset RESET, synchronous, active-high; clock clk.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  global clock
- RESET  in  1  synchronous reset
- STALL  in  1  hold all state
- PCSEL  in  3  next-PC source select
- JT  in  WIDTH  jump target
- SHFT_SEXTC  in  WIDTH  branch offset, already multiplied by 4
- RST_ADDR  in  WIDTH  reset vector
- XADDR  in  WIDTH  interrupt vector base
- ILLOP_ADDR  in  WIDTH  illegal-op vector
- IRQ  in  NUM_IRQ  level-sensitive requests
- CALL  in  1  push return address
- PC_O  out  WIDTH  current PC
- PC_INCR  out  WIDTH  pc+4
- BRANCH_TGT  out  WIDTH  branch target
- IRQ_ACK  out  NUM_IRQ  one-hot acknowledge pulse
- RAS_EMPTY  out  1  stack empty
- RAS_FULL  out  1  stack full
- RAS_UNDERFLOW  out  1  one-cycle pulse on pop while empty

Function
REQ-006 Bit WIDTH-1 of the PC register (S) SHALL be the supervisor flag.
REQ-007 PC_O SHALL equal RST_ADDR while RESET=1 and the PC register otherwise (combinational).
REQ-008 PC_INCR SHALL be pc+4 modulo 2^WIDTH; BRANCH_TGT SHALL be PC_INCR+SHFT_SEXTC modulo 2^WIDTH.
REQ-009 On each clk edge, the update priority SHALL be: RESET > STALL > interrupt > PCSEL.
REQ-010 STALL=1 SHALL hold the pc, the RAS, and the pointers and count, force IRQ_ACK=0 and RAS_UNDERFLOW=0, and ignore CALL.
REQ-011 An interrupt SHALL be taken when any IRQ bit is high and S=0 (tested on PC_O).
- The lowest-index active line i wins.
- pc <= XADDR + 4*i.
- IRQ_ACK bit i = 1 for exactly that one cycle.
- PCSEL and CALL are ignored that cycle.
REQ-012 No interrupt SHALL be taken while S=1; lines remain level-pending, with no internal latch.
REQ-013 PCSEL decode SHALL be:
- 000: {S, PC_INCR[W-2:0]}
- 001: {S, BRANCH_TGT[W-2:0]}
- 010: {S & JT[W-1], JT[W-2:0]}
- 011: ILLOP_ADDR
- 100: XADDR
- 101: RAS pop, giving {S & top[W-1], top[W-2:0]}
- 110 and 111: RST_ADDR
REQ-014 With CALL=1 and PCSEL in {001, 010} and no interrupt taken, PC_INCR SHALL be pushed; CALL with any other PCSEL SHALL be ignored.
REQ-015 The RAS SHALL be a circular buffer with a top pointer and a count that saturates at RAS_DEPTH.
- A push when full overwrites the oldest entry and count stays at RAS_DEPTH.
REQ-016 A pop (PCSEL=101) with count=0 SHALL load pc with ILLOP_ADDR, pulse RAS_UNDERFLOW for one cycle, and leave the pointer and count unchanged.
REQ-017 RAS_EMPTY SHALL be (count==0) and RAS_FULL SHALL be (count==RAS_DEPTH), both derived from registered count.
REQ-018 IRQ_ACK and RAS_UNDERFLOW SHALL be registered outputs.

Reset
REQ-019 While RESET=1 at an edge, the block SHALL set pc <= RST_ADDR, count <= 0, top pointer <= 0, IRQ_ACK <= 0, RAS_UNDERFLOW <= 0; RAS entry contents are don't-care.
REQ-020 RESET SHALL override STALL, IRQ and CALL; a reset mid-call sequence SHALL discard all stacked addresses.
REQ-021 After reset, the outputs SHALL be PC_O=RST_ADDR, RAS_EMPTY=1, RAS_FULL=0, IRQ_ACK=0, RAS_UNDERFLOW=0.

Verification (WIDTH=32, RAS_DEPTH=4, NUM_IRQ=4)
REQ-022 Reset and increment: RST_ADDR=0x8000_0000, RESET for 2 cycles, then PCSEL=000 for 3 cycles -> PC_O = 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C.
REQ-023 Branch and interrupt:
- pc=0x100, PCSEL=001, SHFT_SEXTC=0xFFFF_FFF8 -> pc=0x0000_00FC.
- Then IRQ=0110, XADDR=0x8000_0080 -> pc=0x8000_0084 and IRQ_ACK=0010 for one cycle.
- IRQ held high afterwards -> no further ACK.
REQ-024 Call and return: pc=0x200, CALL=1, PCSEL=010, JT=0x400 -> pc=0x400 and RAS_EMPTY=0; then PCSEL=101 -> pc=0x204 and RAS_EMPTY=1.
REQ-025 Overflow and underflow:
- 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50 -> RAS_FULL=1.
- 5 pops -> returns 0x54, 0x44, 0x34, 0x24.
- The fifth pop -> pc=ILLOP_ADDR and RAS_UNDERFLOW=1 for one cycle.
REQ-026 Stall: STALL=1 with PCSEL=001, CALL=1, IRQ=0001 while pc=0x300 (S=0) for 3 cycles -> pc=0x300, count unchanged, IRQ_ACK=0; STALL drops -> pc=XADDR and IRQ_ACK=0001.
REQ-027 Supervisor clear: pc=0x8000_0010, PCSEL=010, JT=0x0000_0300 -> pc=0x0000_0300; from that user pc, JT=0x8000_0300 -> pc=0x0000_0300 (S cannot be set by jump).

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, vectored interrupts,
// and a circular return-address stack with overflow/underflow handling.
module pc_sequencer #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4,
  parameter int NUM_IRQ   = 4
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               STALL,
  input  logic [2:0]         PCSEL,
  input  logic [WIDTH-1:0]   JT,
  input  logic [WIDTH-1:0]   SHFT_SEXTC,
  input  logic [WIDTH-1:0]   RST_ADDR,
  input  logic [WIDTH-1:0]   XADDR,
  input  logic [WIDTH-1:0]   ILLOP_ADDR,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic               CALL,
  output logic [WIDTH-1:0]   PC_O,
  output logic [WIDTH-1:0]   PC_INCR,
  output logic [WIDTH-1:0]   BRANCH_TGT,
  output logic [NUM_IRQ-1:0] IRQ_ACK,
  output logic               RAS_EMPTY,
  output logic               RAS_FULL,
  output logic               RAS_UNDERFLOW
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] irq_vec;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_dec;
  logic [CW-1:0]    count;
  logic [4:0]       irq_idx;
  logic             s;
  logic             irq_take;
  logic             push;
  logic             pop;
  logic             empty;
  logic             full;

  assign s          = pc[WIDTH-1];
  assign PC_O       = RESET ? RST_ADDR : pc;
  assign PC_INCR    = pc + WIDTH'(4);
  assign BRANCH_TGT = PC_INCR + SHFT_SEXTC;

  assign empty     = (count == '0);
  assign full      = (count == CW'(RAS_DEPTH));
  assign RAS_EMPTY = empty;
  assign RAS_FULL  = full;

  // Supervisor mode masks interrupts; requests stay pending on the wires.
  assign irq_take = (|IRQ) && !PC_O[WIDTH-1];

  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (IRQ[i]) irq_idx = 5'(i);
    end
  end

  assign irq_vec = XADDR + (WIDTH'(irq_idx) << 2);

  assign ptr_dec = ptr - PW'(1);
  assign ras_top = ras[ptr_dec];
  assign push    = CALL && (PCSEL == 3'b001 || PCSEL == 3'b010);
  assign pop     = (PCSEL == 3'b101);

  always_comb begin
    pc_next = RST_ADDR;
    case (PCSEL)
      3'b000: pc_next = {s, PC_INCR[WIDTH-2:0]};
      3'b001: pc_next = {s, BRANCH_TGT[WIDTH-2:0]};
      3'b010: pc_next = {s & JT[WIDTH-1], JT[WIDTH-2:0]};
      3'b011: pc_next = ILLOP_ADDR;
      3'b100: pc_next = XADDR;
      3'b101: pc_next = empty ? ILLOP_ADDR
                              : {s & ras_top[WIDTH-1], ras_top[WIDTH-2:0]};
      default: pc_next = RST_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      pc            <= RST_ADDR;
      ptr           <= '0;
      count         <= '0;
      IRQ_ACK       <= '0;
      RAS_UNDERFLOW <= 1'b0;
    end else if (STALL) begin
      IRQ_ACK       <= '0;
      RAS_UNDERFLOW <= 1'b0;
    end else if (irq_take) begin
      pc            <= irq_vec;
      IRQ_ACK       <= NUM_IRQ'(1) << irq_idx;
      RAS_UNDERFLOW <= 1'b0;
    end else begin
      pc            <= pc_next;
      IRQ_ACK       <= '0;
      RAS_UNDERFLOW <= pop && empty;
      // When full, ptr already addresses the oldest slot, so it is overwritten.
      if (push) begin
        ras[ptr] <= PC_INCR;
        ptr      <= ptr + PW'(1);
        if (!full) count <= count + CW'(1);
      end else if (pop && !empty) begin
        ptr   <= ptr_dec;
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, branch, irq, RAS, stall,
// supervisor-bit behaviour with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        RESET;
  logic        STALL;
  logic [2:0]  PCSEL;
  logic [31:0] JT;
  logic [31:0] SHFT_SEXTC;
  logic [31:0] RST_ADDR;
  logic [31:0] XADDR;
  logic [31:0] ILLOP_ADDR;
  logic [3:0]  IRQ;
  logic        CALL;
  logic [31:0] PC_O;
  logic [31:0] PC_INCR;
  logic [31:0] BRANCH_TGT;
  logic [3:0]  IRQ_ACK;
  logic        RAS_EMPTY;
  logic        RAS_FULL;
  logic        RAS_UNDERFLOW;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.WIDTH(32), .RAS_DEPTH(4), .NUM_IRQ(4)) dut (
    .clk(clk), .RESET(RESET), .STALL(STALL), .PCSEL(PCSEL),
    .JT(JT), .SHFT_SEXTC(SHFT_SEXTC), .RST_ADDR(RST_ADDR),
    .XADDR(XADDR), .ILLOP_ADDR(ILLOP_ADDR), .IRQ(IRQ), .CALL(CALL),
    .PC_O(PC_O), .PC_INCR(PC_INCR), .BRANCH_TGT(BRANCH_TGT),
    .IRQ_ACK(IRQ_ACK), .RAS_EMPTY(RAS_EMPTY), .RAS_FULL(RAS_FULL),
    .RAS_UNDERFLOW(RAS_UNDERFLOW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; PCSEL = 3'b000; CALL = 1'b0;
    JT = '0; SHFT_SEXTC = '0; IRQ = '0;
    RST_ADDR = 32'h8000_0000; XADDR = 32'h8000_0080;
    ILLOP_ADDR = 32'h0000_0F00;

    // reset and increment
    tick(); tick();
    check("rst_pc", PC_O, 32'h8000_0000);
    check("rst_empty", RAS_EMPTY, 1);
    check("rst_full", RAS_FULL, 0);
    check("rst_ack", IRQ_ACK, 0);
    check("rst_uf", RAS_UNDERFLOW, 0);
    RESET = 1'b0; #1;
    check("pc0", PC_O, 32'h8000_0000);
    tick(); check("pc4", PC_O, 32'h8000_0004);
    tick(); check("pc8", PC_O, 32'h8000_0008);
    tick(); check("pcc", PC_O, 32'h8000_000C);
    SHFT_SEXTC = 32'h10; #1;
    check("incr", PC_INCR, 32'h8000_0010);
    check("btgt", BRANCH_TGT, 32'h8000_0020);

    // branch then interrupt
    PCSEL = 3'b010; JT = 32'h100;
    tick(); check("jmp100", PC_O, 32'h100);
    PCSEL = 3'b001; SHFT_SEXTC = 32'hFFFF_FFF8;
    tick(); check("br_back", PC_O, 32'h0000_00FC);
    PCSEL = 3'b000; IRQ = 4'b0110;
    tick();
    check("irq_pc", PC_O, 32'h8000_0084);
    check("irq_ack", IRQ_ACK, 4'b0010);
    tick();
    check("irq_mask_ack", IRQ_ACK, 4'b0000);
    check("irq_mask_pc", PC_O, 32'h8000_0088);
    IRQ = '0;

    // call and return
    PCSEL = 3'b010; JT = 32'h200;
    tick(); check("jmp200", PC_O, 32'h200);
    CALL = 1'b1; JT = 32'h400;
    tick();
    check("call_pc", PC_O, 32'h400);
    check("call_nonempty", RAS_EMPTY, 0);
    CALL = 1'b0; PCSEL = 3'b101;
    tick();
    check("ret_pc", PC_O, 32'h204);
    check("ret_empty", RAS_EMPTY, 1);

    // overflow and underflow
    PCSEL = 3'b010; JT = 32'h10;
    tick(); check("jmp10", PC_O, 32'h10);
    CALL = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      JT = 32'(16 * (k + 1));
      tick();
      check("ovf_call", PC_O, 32'(16 * (k + 1)));
    end
    check("ovf_full", RAS_FULL, 1);
    CALL = 1'b0; PCSEL = 3'b101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("pop_pc", PC_O, 32'(32'h54 - 16 * k));
      check("pop_uf", RAS_UNDERFLOW, 0);
    end
    check("pop_empty", RAS_EMPTY, 1);
    tick();
    check("uf_pc", PC_O, 32'h0000_0F00);
    check("uf_pulse", RAS_UNDERFLOW, 1);
    PCSEL = 3'b000;
    tick();
    check("uf_clear", RAS_UNDERFLOW, 0);
    check("uf_next", PC_O, 32'h0000_0F04);

    // stall holds everything
    PCSEL = 3'b010; CALL = 1'b1; JT = 32'h300;
    tick();
    check("st_setup_pc", PC_O, 32'h300);
    check("st_setup_ne", RAS_EMPTY, 0);
    STALL = 1'b1; PCSEL = 3'b001; SHFT_SEXTC = 32'h40;
    IRQ = 4'b0001; XADDR = 32'h0000_0500;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("st_pc", PC_O, 32'h300);
      check("st_ack", IRQ_ACK, 0);
    end
    STALL = 1'b0;
    tick();
    check("st_irq_pc", PC_O, 32'h500);
    check("st_irq_ack", IRQ_ACK, 4'b0001);
    IRQ = '0; CALL = 1'b0; PCSEL = 3'b101;
    tick();
    check("st_ret_pc", PC_O, 32'hF08);
    check("st_ret_empty", RAS_EMPTY, 1);

    // reset mid-call discards stack and beats stall/irq
    PCSEL = 3'b010; CALL = 1'b1; JT = 32'h600;
    tick(); check("mc_ne", RAS_EMPTY, 0);
    RESET = 1'b1; STALL = 1'b1; IRQ = 4'b0001;
    RST_ADDR = 32'h8000_0010; #1;
    check("rst_comb", PC_O, 32'h8000_0010);
    tick();
    RESET = 1'b0; STALL = 1'b0; IRQ = '0; CALL = 1'b0; #1;
    check("mc_pc", PC_O, 32'h8000_0010);
    check("mc_empty", RAS_EMPTY, 1);
    check("mc_ack", IRQ_ACK, 0);

    // jumps cannot set supervisor bit
    PCSEL = 3'b010; JT = 32'h0000_0300;
    tick(); check("sv_clear", PC_O, 32'h0000_0300);
    JT = 32'h8000_0300;
    tick(); check("sv_noset", PC_O, 32'h0000_0300);

    // fixed vectors
    PCSEL = 3'b011;
    tick(); check("sel_illop", PC_O, 32'h0000_0F00);
    PCSEL = 3'b100;
    tick(); check("sel_xaddr", PC_O, 32'h0000_0500);
    PCSEL = 3'b111;
    tick(); check("sel_rst", PC_O, 32'h8000_0010);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
